// File: rtl/nibble_serial_sub_if.sv
// nibble_serial_sub_if: request/result bundle for the digit-serial subtractor.
//   start, a, b, bin         : operation request and operands (driven by the controller)
//   busy, done, diff, bout,
//   zero, ovf                : status and registered result (driven by the subtractor)
// Modports: master = controller side, slave = subtractor side.
interface nibble_serial_sub_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero, ovf
  );
endinterface

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: computes a - b - bin one 4-bit nibble per clock, LSB first.
// Each step is a 4-bit carry-lookahead add of a_nib + ~b_nib + carry, where the
// carry between nibbles is the inverted borrow and lives in a register.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of nibble_serial_sub_if (start/a/b/bin in,
//          busy/done/diff/bout/zero/ovf out, all outputs registered)
module nibble_serial_sub #(
  parameter int NIBBLES = 4
) (
  input logic                clk,
  input logic                rst,
  nibble_serial_sub_if.slave bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     work_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx_r;

  logic [3:0]       a_nib_s;
  logic [3:0]       b_nib_s;
  logic [4:0]       sum_s;
  logic [W-1:0]     result_s;
  logic             last_s;

  // 4-bit carry-lookahead adder; returns {carry_out, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Current nibble step and the working word with that nibble merged in, so the
  // final step can publish the complete result in the same edge.
  always_comb begin
    a_nib_s  = a_r[{idx_r, 2'b00} +: 4];
    b_nib_s  = b_r[{idx_r, 2'b00} +: 4];
    sum_s    = cla4(a_nib_s, ~b_nib_s, carry_r);
    result_s = work_r;
    result_s[{idx_r, 2'b00} +: 4] = sum_s[3:0];
    last_s   = (idx_r == LAST_IDX);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RUN;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Operand capture, per-nibble datapath and registered result/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      work_r   <= '0;
      carry_r  <= 1'b0;
      idx_r    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
      bus.zero <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            work_r   <= '0;
            carry_r  <= ~bus.bin;
            idx_r    <= '0;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          work_r  <= result_s;
          carry_r <= sum_s[4];
          if (last_s) begin
            idx_r    <= '0;
            bus.diff <= result_s;
            bus.bout <= ~sum_s[4];
            bus.zero <= (result_s == '0);
            // Signed overflow: operands of opposite sign and result sign differs from a.
            bus.ovf  <= (a_r[W-1] != b_r[W-1]) && (result_s[W-1] != a_r[W-1]);
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
